// File: rtl/dec_lut_req_ctrl.sv
// Request sequencer for the DEC LUT decoder: launches one word, masks stale found
// during settle, waits (with watchdog) for found, and returns the captured N.
module dec_lut_req_ctrl #(
   parameter int W_BITS   = 39,
   parameter int N_BITS   = 25,
   parameter int SETTLE   = 2,
   parameter int MAX_WAIT = 1024,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_BITS-1:0] in_w,
   output logic [W_BITS-1:0] dec_w,
   input  logic              dec_found,
   input  logic [N_BITS-1:0] dec_n,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] out_n,
   output logic              out_timeout,
   output logic [CNT_W-1:0]  req_cnt,
   output logic [CNT_W-1:0]  tmo_cnt
);

   localparam int WC_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
   localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, SETTLE_ST, WAIT, DONE} state_e;

   state_e            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              out_timeout_q, out_timeout_d;
   logic [W_BITS-1:0] dec_w_q, dec_w_d;
   logic [N_BITS-1:0] out_n_q, out_n_d;
   logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [3:0]        settle_q, settle_d;
   logic [WC_W-1:0]   wait_q, wait_d;

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q;
      out_timeout_d = out_timeout_q;
      dec_w_d       = dec_w_q;
      out_n_d       = out_n_q;
      req_cnt_d     = req_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      settle_d      = settle_q;
      wait_d        = wait_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               dec_w_d   = in_w;
               req_cnt_d = (req_cnt_q == '1) ? req_cnt_q : req_cnt_q + 1'b1;
               settle_d  = SETTLE_L;
               state_d   = SETTLE_ST;
            end
         end
         SETTLE_ST: begin
            // Counter reaching 0 on this edge means WAIT starts SETTLE cycles after accept.
            settle_d = settle_q - 4'd1;
            if (settle_q <= 4'd1) begin
               wait_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dec_found) begin
               out_n_d       = dec_n;
               out_timeout_d = 1'b0;
               out_valid_d   = 1'b1;
               state_d       = DONE;
            end else if (wait_q == WAIT_LIM) begin
               out_n_d       = '0;
               out_timeout_d = 1'b1;
               out_valid_d   = 1'b1;
               tmo_cnt_d     = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
               state_d       = DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         out_timeout_q <= 1'b0;
         dec_w_q       <= '0;
         out_n_q       <= '0;
         req_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         settle_q      <= '0;
         wait_q        <= '0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_timeout_q <= out_timeout_d;
         dec_w_q       <= dec_w_d;
         out_n_q       <= out_n_d;
         req_cnt_q     <= req_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         settle_q      <= settle_d;
         wait_q        <= wait_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_timeout = out_timeout_q;
   assign dec_w       = dec_w_q;
   assign out_n       = out_n_q;
   assign req_cnt     = req_cnt_q;
   assign tmo_cnt     = tmo_cnt_q;

endmodule

// File: tb/tb_dec_lut_req_ctrl.sv
// Scoreboard bench for dec_lut_req_ctrl (MAX_WAIT = 8): stimulus pushes expected
// results with their capture cycle; a negedge monitor pops on each new out_valid.
module tb_dec_lut_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [38:0] in_w = '0;
   logic [38:0] dec_w;
   logic        dec_found = 1'b0;
   logic [24:0] dec_n = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [24:0] out_n;
   logic        out_timeout;
   logic [15:0] req_cnt;
   logic [15:0] tmo_cnt;

   typedef struct {
      logic [24:0] n;
      logic        to;
      logic [15:0] req;
      logic [15:0] tmo;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   dec_lut_req_ctrl #(.W_BITS(39), .N_BITS(25), .SETTLE(2), .MAX_WAIT(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
      .dec_w(dec_w), .dec_found(dec_found), .dec_n(dec_n), .out_valid(out_valid),
      .out_ready(out_ready), .out_n(out_n), .out_timeout(out_timeout),
      .req_cnt(req_cnt), .tmo_cnt(tmo_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: each rising out_valid is a new result and must match the queue head.
   always @(negedge clk) begin
      if (out_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_result: got out_valid=1 at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_cycle", cyc, e.cyc);
            chk("res_out_n", out_n, e.n);
            chk("res_timeout", out_timeout, e.to);
            chk("res_req_cnt", req_cnt, e.req);
            chk("res_tmo_cnt", tmo_cnt, e.tmo);
         end
      end
      prev_valid <= out_valid;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [38:0] w, output int acc);
      int n = 0;
      while (!in_ready && n < 200) begin step(); n++; end
      if (!in_ready) chk("send_in_ready_wait", 0, 1);
      in_w = w; in_valid = 1'b1;
      step();
      acc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin step(); n++; end
      if (sb.size() != 0) chk("drain_budget", sb.size(), 0);
      step(); step();
   endtask

   task automatic push(input logic [24:0] n, input logic to, input int rq, input int tm,
                       input int c);
      exp_t e;
      e.n = n; e.to = to; e.req = 16'(rq); e.tmo = 16'(tm); e.cyc = c;
      sb.push_back(e);
   endtask

   initial begin
      int acc;
      step(); step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dec_w", dec_w, 0);
      chk("rst_out_n", out_n, 0);
      chk("rst_req_cnt", req_cnt, 0);
      rst_n = 1'b1;
      step();

      // Basic decode: found rises 3 cycles after WAIT entry.
      dec_n = 25'd16777215;
      send(39'd5, acc);
      push(25'd16777215, 1'b0, 1, 0, acc + 5);
      chk("t1_in_ready_low", in_ready, 0);
      repeat (4) step();
      dec_found = 1'b1;
      step();
      dec_found = 1'b0;
      drain();
      chk("t1_dec_w_hold", dec_w, 5);

      // Stale found held high across two back-to-back requests.
      dec_found = 1'b1; dec_n = 25'h0ABCDE;
      send(39'h12_3456_789A, acc);
      push(25'h0ABCDE, 1'b0, 2, 0, acc + 3);
      send(39'h7F_0000_0001, acc);
      push(25'h0ABCDE, 1'b0, 3, 0, acc + 3);
      for (int i = 0; i < 4; i++) begin
         chk("t2_dec_w_new", dec_w, 39'h7F_0000_0001);
         step();
      end
      drain();
      dec_found = 1'b0;

      // Timeout: found never arrives, result 8 cycles after WAIT entry.
      send(39'd77, acc);
      push(25'd0, 1'b1, 4, 1, acc + 10);
      drain();

      // Backpressure: result held 20 cycles, upstream pulses ignored.
      out_ready = 1'b0; dec_found = 1'b1; dec_n = 25'h155_5555;
      send(39'd99, acc);
      push(25'h155_5555, 1'b0, 5, 1, acc + 3);
      repeat (4) step();
      dec_found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0]; in_w = 39'(i + 1000);
         step();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_n", out_n, 25'h155_5555);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_req_cnt", req_cnt, 5);
         chk("bp_dec_w", dec_w, 99);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_released", out_valid, 0);
      step();
      chk("bp_in_ready_back", in_ready, 1);

      // Reset in the middle of WAIT: everything back to reset values, no result.
      send(39'd1234, acc);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_dec_w", dec_w, 0);
      chk("mid_rst_out_n", out_n, 0);
      chk("mid_rst_timeout", out_timeout, 0);
      chk("mid_rst_req_cnt", req_cnt, 0);
      chk("mid_rst_tmo_cnt", tmo_cnt, 0);
      repeat (15) step();

      // Found on the same edge the watchdog limit is reached: found wins.
      dec_n = 25'd4242;
      send(39'd8, acc);
      push(25'd4242, 1'b0, 1, 0, acc + 10);
      repeat (9) step();
      dec_found = 1'b1;
      step();
      dec_found = 1'b0;
      drain();
      chk("coinc_tmo_cnt", tmo_cnt, 0);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
